// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, gates decoder strobes and halts on exception or bus timeout.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_ready,
    output logic             fetch_req,
    output logic             ir_load,
    input  logic             dec_except,
    input  logic             dec_writeenable,
    input  logic             dec_mem_read,
    input  logic             dec_word_we,
    input  logic             dec_byte_we,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_word_we,
    output logic             mem_byte_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_halt;
    logic              r_bus_error;
    logic [CNT_W-1:0]  r_count;

    logic w_memop;
    logic w_ready;
    logic w_timeout;
    logic w_pc_we;

    // Strobes are decoded straight from state so they vanish the instant reset rises.
    always_comb begin
        w_memop   = dec_mem_read | dec_word_we | dec_byte_we;
        w_ready   = (r_state == S_FETCH) ? inst_ready : mem_ready;
        w_timeout = ((r_state == S_FETCH) || (r_state == S_MEM)) && !w_ready
                    && (r_wait == WAIT_LAST);

        fetch_req   = !reset && (r_state == S_FETCH);
        ir_load     = !reset && (r_state == S_FETCH) && inst_ready;
        mem_req     = !reset && (r_state == S_MEM);
        mem_word_we = !reset && (r_state == S_MEM) && dec_word_we;
        mem_byte_we = !reset && (r_state == S_MEM) && dec_byte_we;
        rf_we       = !reset && (((r_state == S_EXEC) && !w_memop && dec_writeenable)
                                 || (r_state == S_WB));
        w_pc_we     = !reset && (((r_state == S_EXEC) && !w_memop)
                                 || (r_state == S_WB)
                                 || ((r_state == S_MEM) && mem_ready && !dec_mem_read));
        pc_we       = w_pc_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_wait      <= '0;
            r_halt      <= 1'b0;
            r_bus_error <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (inst_ready) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state     <= S_HALT;
                        r_halt      <= 1'b1;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_except) begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= w_memop ? S_MEM : S_FETCH;
                    r_wait  <= '0;
                end
                // Ready arriving on the last permitted wait cycle still completes the access.
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= dec_mem_read ? S_WB : S_FETCH;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state     <= S_HALT;
                        r_halt      <= 1'b1;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state <= S_HALT;
                    r_halt  <= 1'b1;
                end
            endcase
            if (w_pc_we) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign halt        = r_halt;
    assign bus_error   = r_bus_error;
    assign instr_count = r_count;
    assign state       = r_state;

endmodule
